d_sr_bank: RTL and testbench

- WIDTH-bit bank of SR flip-flops built on plain D storage. Per bit, next-state D = S | (~R & Q); this is the SR-from-D conversion, the inverse of the team's D-from-SR cell.
- Gives SR-style control/status bits to downstream logic through one clocked register.
- Resolves the forbidden S=R=1 input by a fixed policy, never by driving X.
- Flags and counts every forbidden event for debug.

---
 rtl/d_sr_pkg.sv | 35 +++
 rtl/d_sr_cell.sv | 39 +++
 rtl/d_sr_bank.sv | 91 +++++++++
 tb/tb_d_sr_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/d_sr_pkg.sv
// d_sr_pkg: shared definitions for the SR-on-D register bank.
//   POL_*    : encodings for resolving the forbidden S=R=1 input.
//   next_sr  : 1-bit next-state function (q, s, r, policy) -> q_next.
//              It covers only the enabled case. The caller gates it with en.
package d_sr_pkg;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
  localparam int POL_TOG  = 3;

  // This is the SR-from-D conversion D = S | (~R & Q), with an explicit
  // resolution for S=R=1. Policy values outside 0..3 fall back to hold,
  // so the bit never goes to X.
  function automatic logic next_sr(input logic q, input logic s,
                                   input logic r, input int policy);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00: nxt = q;
      2'b01: nxt = 1'b0;
      2'b10: nxt = 1'b1;
      default: begin
        case (policy)
          POL_SET: nxt = 1'b1;
          POL_RST: nxt = 1'b0;
          POL_TOG: nxt = ~q;
          default: nxt = q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/d_sr_cell.sv
// d_sr_cell: one SR bit built on a D flop.
// Ports:
//   clk, rst : clock and synchronous active-high reset. Reset loads RST_BIT.
//   en       : clock enable. With en=0 the bit holds and no forbidden event is reported.
//   s, r     : set and reset inputs for this bit.
//   q        : stored state, registered.
//   fb       : combinational forbidden detect, en & s & r.
module d_sr_cell
  import d_sr_pkg::*;
#(
  parameter int   POLICY  = POL_HOLD,
  parameter logic RST_BIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic fb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = next_sr(q_q, s, r, POLICY);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_BIT;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign fb = en & s & r;

endmodule

// File: rtl/d_sr_bank.sv
// d_sr_bank: a WIDTH-bit bank of SR flip-flops with forbidden-input tracking.
// Ports:
//   clk, rst  : clock and synchronous active-high reset. Reset has priority over all other inputs.
//   en        : clock enable for S/R sampling.
//   s, r      : per-bit set and reset inputs, WIDTH bits each.
//   clr_err   : single-cycle clear of err_flag and err_cnt.
//               A forbidden event in the same cycle takes priority over the clear.
//   q, qbar   : stored state and its inverse. qbar is derived from q and is not stored.
//   err_flag  : sticky per-bit flags, one per bit that has seen S=R=1.
//   any_err   : registered OR-reduction of err_flag.
//   err_cnt   : saturating count of cycles with at least one forbidden bit.
module d_sr_bank
  import d_sr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}},
  parameter int               POLICY  = POL_HOLD,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err_flag,
  output logic             any_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] fb;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    d_sr_cell #(
      .POLICY  (POLICY),
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .s   (s[i]),
      .r   (r[i]),
      .q   (q[i]),
      .fb  (fb[i])
    );
  end

  assign qbar = ~q;

  logic [WIDTH-1:0] err_flag_q, err_flag_d;
  logic             any_err_q, any_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             any_fb;

  assign any_fb = |fb;

  always_comb begin
    err_flag_d = err_flag_q | fb;
    err_cnt_d  = err_cnt_q;
    if (clr_err) begin
      // The clear removes old history. A forbidden event in the same cycle is still recorded.
      err_flag_d = fb;
      err_cnt_d  = any_fb ? CNT_W'(1) : '0;
    end else if (any_fb && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    // any_err is built from the next flag value, so it changes on the same edge as err_flag.
    any_err_d = |err_flag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q <= '0;
      any_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      any_err_q  <= any_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_flag = err_flag_q;
  assign any_err  = any_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_d_sr_bank.sv
// Testbench for d_sr_bank. Four instances run with the same stimulus:
// POLICY 0, 1 and 2 use an 8-bit counter, and POLICY 3 uses a 2-bit counter.
module tb_d_sr_bank;

  localparam int W     = 8;
  localparam int NI    = 4;
  localparam int ENT_W = 25;            // q(8) flag(8) any(1) cnt(8)
  localparam int EXP_W = NI * ENT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] s = '0;
  logic [W-1:0] r = '0;
  logic         clr_err = 1'b0;

  logic [W-1:0] q_o[NI];
  logic [W-1:0] qbar_o[NI];
  logic [W-1:0] flag_o[NI];
  logic         any_o[NI];
  logic [7:0]   cnt_o[NI];
  logic [1:0]   cnt3;

  d_sr_bank #(.WIDTH(W), .RST_VAL(8'hFF), .POLICY(0), .CNT_W(8)) u_p0 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[0]), .qbar(qbar_o[0]), .err_flag(flag_o[0]), .any_err(any_o[0]),
    .err_cnt(cnt_o[0]));
  d_sr_bank #(.WIDTH(W), .RST_VAL(8'hFF), .POLICY(1), .CNT_W(8)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[1]), .qbar(qbar_o[1]), .err_flag(flag_o[1]), .any_err(any_o[1]),
    .err_cnt(cnt_o[1]));
  d_sr_bank #(.WIDTH(W), .RST_VAL(8'hFF), .POLICY(2), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[2]), .qbar(qbar_o[2]), .err_flag(flag_o[2]), .any_err(any_o[2]),
    .err_cnt(cnt_o[2]));
  d_sr_bank #(.WIDTH(W), .RST_VAL(8'hFF), .POLICY(3), .CNT_W(2)) u_p3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[3]), .qbar(qbar_o[3]), .err_flag(flag_o[3]), .any_err(any_o[3]),
    .err_cnt(cnt3));
  assign cnt_o[3] = {6'b0, cnt3};

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, one entry per instance
  logic [W-1:0] m_q[NI];
  logic [W-1:0] m_flag[NI];
  logic [7:0]   m_cnt[NI];
  logic [7:0]   m_max[NI];

  task automatic model_step(input logic i_rst, input logic i_en,
                            input logic [W-1:0] i_s, input logic [W-1:0] i_r,
                            input logic i_clr);
    logic [W-1:0] fbv;
    fbv = i_en ? (i_s & i_r) : '0;
    for (int k = 0; k < NI; k++) begin
      if (i_rst) begin
        m_q[k] = 8'hFF; m_flag[k] = '0; m_cnt[k] = '0;
      end else begin
        if (i_en) begin
          for (int b = 0; b < W; b++) begin
            if (i_s[b] && !i_r[b])      m_q[k][b] = 1'b1;
            else if (!i_s[b] && i_r[b]) m_q[k][b] = 1'b0;
            else if (i_s[b] && i_r[b]) begin
              if (k == 1)      m_q[k][b] = 1'b1;
              else if (k == 2) m_q[k][b] = 1'b0;
              else if (k == 3) m_q[k][b] = ~m_q[k][b];
            end
          end
        end
        if (i_clr) begin
          m_flag[k] = fbv;
          m_cnt[k]  = (fbv != 0) ? 8'd1 : 8'd0;
        end else begin
          m_flag[k] = m_flag[k] | fbv;
          if (fbv != 0 && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 8'd1;
        end
      end
    end
  endtask

  // Drive one cycle: the inputs change at negedge, the expected result is queued,
  // and the outputs are compared 1 time unit after the next posedge.
  task automatic cycle(input logic i_rst, input logic i_en,
                       input logic [W-1:0] i_s, input logic [W-1:0] i_r,
                       input logic i_clr);
    logic [EXP_W-1:0] ent;
    logic [ENT_W-1:0] e;
    @(negedge clk);
    rst = i_rst; en = i_en; s = i_s; r = i_r; clr_err = i_clr;
    model_step(i_rst, i_en, i_s, i_r, i_clr);
    for (int k = 0; k < NI; k++)
      ent[k*ENT_W +: ENT_W] = {m_q[k], m_flag[k], (m_flag[k] != 0), m_cnt[k]};
    exp_q.push_back(ent);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      ent = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        e = ent[k*ENT_W +: ENT_W];
        check_eq($sformatf("p%0d_q", k),    {24'b0, q_o[k]},    {24'b0, e[24:17]});
        check_eq($sformatf("p%0d_qbar", k), {24'b0, qbar_o[k]}, {24'b0, ~e[24:17]});
        check_eq($sformatf("p%0d_flag", k), {24'b0, flag_o[k]}, {24'b0, e[16:9]});
        check_eq($sformatf("p%0d_any", k),  {31'b0, any_o[k]},  {31'b0, e[8]});
        check_eq($sformatf("p%0d_cnt", k),  {24'b0, cnt_o[k]},  {24'b0, e[7:0]});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_q[k] = 'x; m_flag[k] = 'x; m_cnt[k] = 'x; m_max[k] = 8'hFF;
    end
    m_max[3] = 8'd3;

    // reset for two cycles, then r=0F brings q to F0
    cycle(1, 0, 8'h00, 8'h00, 0);
    cycle(1, 0, 8'h00, 8'h00, 0);
    check_eq("rst_q_const", {24'b0, q_o[0]}, 32'hFF);
    check_eq("rst_cnt_const", {24'b0, cnt_o[0]}, 32'h0);
    cycle(0, 1, 8'h00, 8'h0F, 0);
    check_eq("q_f0_const", {24'b0, q_o[0]}, 32'hF0);

    // bit 0: set, then hold, then reset
    cycle(0, 1, 8'h01, 8'h00, 0);
    cycle(0, 1, 8'h00, 8'h00, 0);
    cycle(0, 1, 8'h00, 8'h01, 0);

    // forbidden on bits 7 and 0 for 4 cycles (the CNT_W=2 instance saturates)
    for (int n = 0; n < 4; n++) cycle(0, 1, 8'h81, 8'h81, 0);
    check_eq("cnt4_const", {24'b0, cnt_o[0]}, 32'd4);
    cycle(0, 1, 8'h81, 8'h81, 0);       // fifth forbidden cycle: cnt3 stays at 3
    check_eq("sat_const", {24'b0, cnt_o[3]}, 32'd3);

    // clr_err together with a new event on bit 2, then clr_err alone
    cycle(0, 1, 8'h04, 8'h04, 1);
    check_eq("clr_new_flag_const", {24'b0, flag_o[0]}, 32'h04);
    cycle(0, 1, 8'h00, 8'h00, 1);

    // en=0 gating
    cycle(0, 0, 8'hFF, 8'hFF, 0);

    // policy comparison from q=0F
    cycle(1, 0, 8'h00, 8'h00, 0);
    cycle(0, 1, 8'h00, 8'hF0, 0);
    cycle(0, 1, 8'hFF, 8'hFF, 0);
    check_eq("tog_const", {24'b0, q_o[3]}, 32'hF0);

    // reset during a forbidden cycle
    cycle(0, 1, 8'h3C, 8'h00, 0);
    cycle(1, 1, 8'hFF, 8'hFF, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0));
    end

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
